butterfly_r2_pipe: RTL and testbench

BUTTERFLY_R2_PIPE -- requirements
Module: butterfly_r2_pipe

---
 rtl/butterfly_r2_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_butterfly_r2_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_r2_pipe.sv
// Radix-2 DIT butterfly, 3-stage pipeline: ya = a + b*W, yb = a - b*W.
// Trivial twiddles (1, -j, -1) bypass the multipliers; general twiddles round and saturate.
module butterfly_r2_pipe #(
    parameter int unsigned  DATA_W = 16,
    parameter int unsigned  TW_W   = 16,
    localparam int unsigned OUT_W  = DATA_W + 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] xa_re,
    input  logic signed [DATA_W-1:0] xa_im,
    input  logic signed [DATA_W-1:0] xb_re,
    input  logic signed [DATA_W-1:0] xb_im,
    input  logic [1:0]               tw_mode,
    input  logic signed [TW_W-1:0]   tw_re,
    input  logic signed [TW_W-1:0]   tw_im,
    input  logic                     scale_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  ya_re,
    output logic signed [OUT_W-1:0]  ya_im,
    output logic signed [OUT_W-1:0]  yb_re,
    output logic signed [OUT_W-1:0]  yb_im,
    output logic                     sat
);

    localparam int unsigned BW = DATA_W + 1;
    localparam int unsigned PW = DATA_W + TW_W + 1;
    localparam logic signed [PW-1:0] RND     = PW'(1) << (TW_W - 2);
    localparam logic signed [PW-1:0] SAT_MAX = PW'($signed({1'b0, {DATA_W{1'b1}}}));
    localparam logic signed [PW-1:0] SAT_MIN = PW'($signed({1'b1, {DATA_W{1'b0}}}));

    // Clamp a rounded product to BW signed bits; MSB of the result flags saturation.
    function automatic logic [BW:0] clip(input logic signed [PW-1:0] x);
        if (x > SAT_MAX)      return {1'b1, SAT_MAX[BW-1:0]};
        else if (x < SAT_MIN) return {1'b1, SAT_MIN[BW-1:0]};
        else                  return {1'b0, x[BW-1:0]};
    endfunction

    function automatic logic signed [OUT_W-1:0] halve(input logic signed [OUT_W-1:0] s);
        logic signed [OUT_W-1:0] t;
        t = s + OUT_W'(1);
        return t >>> 1;
    endfunction

    logic advance;

    logic                     v1_q, v1_d, scl1_q, scl1_d;
    logic signed [DATA_W-1:0] a_re1_q, a_re1_d, a_im1_q, a_im1_d;
    logic signed [DATA_W-1:0] b_re1_q, b_re1_d, b_im1_q, b_im1_d;
    logic [1:0]               mode1_q, mode1_d;
    logic signed [TW_W-1:0]   w_re1_q, w_re1_d, w_im1_q, w_im1_d;

    logic                     v2_q, v2_d, scl2_q, scl2_d, sat2_q, sat2_d;
    logic signed [DATA_W-1:0] a_re2_q, a_re2_d, a_im2_q, a_im2_d;
    logic signed [BW-1:0]     bp_re2_q, bp_re2_d, bp_im2_q, bp_im2_d;

    logic                     out_valid_q, out_valid_d, sat_q, sat_d;
    logic signed [OUT_W-1:0]  ya_re_q, ya_re_d, ya_im_q, ya_im_d;
    logic signed [OUT_W-1:0]  yb_re_q, yb_re_d, yb_im_q, yb_im_d;

    logic signed [BW-1:0]     bx_re, bx_im, bp_re, bp_im;
    logic signed [PW-1:0]     br_x, bi_x, wr_x, wi_x, pr_full, pi_full, pr_sh, pi_sh;
    logic [BW:0]              cr_re, cr_im;
    logic                     bp_sat;
    logic signed [OUT_W-1:0]  sa_re, sa_im, sb_re, sb_im;

    // The whole pipe moves in lock-step whenever the output slot is free or being drained.
    assign advance  = out_ready | ~out_valid_q;
    assign in_ready = advance;

    always_comb begin : s1_next
        v1_d    = v1_q;
        a_re1_d = a_re1_q;
        a_im1_d = a_im1_q;
        b_re1_d = b_re1_q;
        b_im1_d = b_im1_q;
        mode1_d = mode1_q;
        w_re1_d = w_re1_q;
        w_im1_d = w_im1_q;
        scl1_d  = scl1_q;
        if (advance) begin
            v1_d    = in_valid;
            a_re1_d = xa_re;
            a_im1_d = xa_im;
            b_re1_d = xb_re;
            b_im1_d = xb_im;
            mode1_d = tw_mode;
            w_re1_d = tw_re;
            w_im1_d = tw_im;
            scl1_d  = scale_en;
        end
    end

    always_comb begin : twiddle
        bx_re   = BW'(b_re1_q);
        bx_im   = BW'(b_im1_q);
        br_x    = PW'(b_re1_q);
        bi_x    = PW'(b_im1_q);
        wr_x    = PW'(w_re1_q);
        wi_x    = PW'(w_im1_q);
        pr_full = br_x * wr_x - bi_x * wi_x;
        pi_full = br_x * wi_x + bi_x * wr_x;
        pr_sh   = (pr_full + RND) >>> (TW_W - 1);
        pi_sh   = (pi_full + RND) >>> (TW_W - 1);
        cr_re   = clip(pr_sh);
        cr_im   = clip(pi_sh);
        bp_re   = bx_re;
        bp_im   = bx_im;
        bp_sat  = 1'b0;
        case (mode1_q)
            2'd1: begin
                bp_re = bx_im;
                bp_im = -bx_re;
            end
            2'd2: begin
                bp_re = -bx_re;
                bp_im = -bx_im;
            end
            2'd3: begin
                bp_re  = $signed(cr_re[BW-1:0]);
                bp_im  = $signed(cr_im[BW-1:0]);
                bp_sat = cr_re[BW] | cr_im[BW];
            end
            default: ;
        endcase
    end

    always_comb begin : s2_next
        v2_d     = v2_q;
        a_re2_d  = a_re2_q;
        a_im2_d  = a_im2_q;
        bp_re2_d = bp_re2_q;
        bp_im2_d = bp_im2_q;
        scl2_d   = scl2_q;
        sat2_d   = sat2_q;
        if (advance) begin
            v2_d     = v1_q;
            a_re2_d  = a_re1_q;
            a_im2_d  = a_im1_q;
            bp_re2_d = bp_re;
            bp_im2_d = bp_im;
            scl2_d   = scl1_q;
            sat2_d   = bp_sat;
        end
    end

    always_comb begin : s3_next
        sa_re       = OUT_W'(a_re2_q) + OUT_W'(bp_re2_q);
        sa_im       = OUT_W'(a_im2_q) + OUT_W'(bp_im2_q);
        sb_re       = OUT_W'(a_re2_q) - OUT_W'(bp_re2_q);
        sb_im       = OUT_W'(a_im2_q) - OUT_W'(bp_im2_q);
        out_valid_d = out_valid_q;
        ya_re_d     = ya_re_q;
        ya_im_d     = ya_im_q;
        yb_re_d     = yb_re_q;
        yb_im_d     = yb_im_q;
        sat_d       = sat_q;
        if (advance) begin
            out_valid_d = v2_q;
            ya_re_d     = scl2_q ? halve(sa_re) : sa_re;
            ya_im_d     = scl2_q ? halve(sa_im) : sa_im;
            yb_re_d     = scl2_q ? halve(sb_re) : sb_re;
            yb_im_d     = scl2_q ? halve(sb_im) : sb_im;
            sat_d       = sat2_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1_q        <= 1'b0;
            a_re1_q     <= '0;
            a_im1_q     <= '0;
            b_re1_q     <= '0;
            b_im1_q     <= '0;
            mode1_q     <= '0;
            w_re1_q     <= '0;
            w_im1_q     <= '0;
            scl1_q      <= 1'b0;
            v2_q        <= 1'b0;
            a_re2_q     <= '0;
            a_im2_q     <= '0;
            bp_re2_q    <= '0;
            bp_im2_q    <= '0;
            scl2_q      <= 1'b0;
            sat2_q      <= 1'b0;
            out_valid_q <= 1'b0;
            ya_re_q     <= '0;
            ya_im_q     <= '0;
            yb_re_q     <= '0;
            yb_im_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            a_re1_q     <= a_re1_d;
            a_im1_q     <= a_im1_d;
            b_re1_q     <= b_re1_d;
            b_im1_q     <= b_im1_d;
            mode1_q     <= mode1_d;
            w_re1_q     <= w_re1_d;
            w_im1_q     <= w_im1_d;
            scl1_q      <= scl1_d;
            v2_q        <= v2_d;
            a_re2_q     <= a_re2_d;
            a_im2_q     <= a_im2_d;
            bp_re2_q    <= bp_re2_d;
            bp_im2_q    <= bp_im2_d;
            scl2_q      <= scl2_d;
            sat2_q      <= sat2_d;
            out_valid_q <= out_valid_d;
            ya_re_q     <= ya_re_d;
            ya_im_q     <= ya_im_d;
            yb_re_q     <= yb_re_d;
            yb_im_q     <= yb_im_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ya_re     = ya_re_q;
    assign ya_im     = ya_im_q;
    assign yb_re     = yb_re_q;
    assign yb_im     = yb_im_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Directed bench for butterfly_r2_pipe: scoreboard queue of expected results,
// popped on each output handshake; stall stability and reset behaviour checked inline.
module tb_butterfly_r2_pipe;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned TW_W   = 16;
    localparam int unsigned OUT_W  = DATA_W + 2;

    logic                     clock = 1'b0;
    logic                     reset_n;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] xa_re, xa_im, xb_re, xb_im;
    logic [1:0]               tw_mode;
    logic signed [TW_W-1:0]   tw_re, tw_im;
    logic                     scale_en;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  ya_re, ya_im, yb_re, yb_im;
    logic                     sat;

    always #5 clock = ~clock;

    butterfly_r2_pipe #(.DATA_W(DATA_W), .TW_W(TW_W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .xa_re    (xa_re),
        .xa_im    (xa_im),
        .xb_re    (xb_re),
        .xb_im    (xb_im),
        .tw_mode  (tw_mode),
        .tw_re    (tw_re),
        .tw_im    (tw_im),
        .scale_en (scale_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ya_re    (ya_re),
        .ya_im    (ya_im),
        .yb_re    (yb_re),
        .yb_im    (yb_im),
        .sat      (sat)
    );

    typedef struct {
        longint ya_re;
        longint ya_im;
        longint yb_re;
        longint yb_im;
        logic   sat;
        int     acc;
        logic   lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_left = 0;
    int   n_out = 0;

    logic                    hold_v = 1'b0;
    logic signed [OUT_W-1:0] h_ya_re, h_ya_im, h_yb_re, h_yb_im;
    logic                    h_sat;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input longint yar, input longint yai, input longint ybr,
                                input longint ybi, input logic s, input logic lat);
        exp_t e;
        e.ya_re = yar; e.ya_im = yai; e.yb_re = ybr; e.yb_im = ybi;
        e.sat = s; e.acc = 0; e.lat = lat;
        return e;
    endfunction

    function automatic longint clamp17(input longint x, inout logic s);
        if (x > 65535)  begin s = 1'b1; return 65535;  end
        if (x < -65536) begin s = 1'b1; return -65536; end
        return x;
    endfunction

    // Reference butterfly in wide integer arithmetic.
    function automatic exp_t model(input longint ar, input longint ai, input longint br, input longint bi,
                                   input logic [1:0] m, input longint wr, input longint wi, input logic sc);
        longint pr, pi, yar, yai, ybr, ybi;
        logic   s;
        s = 1'b0;
        case (m)
            2'd0: begin pr = br;  pi = bi;  end
            2'd1: begin pr = bi;  pi = -br; end
            2'd2: begin pr = -br; pi = -bi; end
            default: begin
                pr = clamp17((br * wr - bi * wi + 16384) >>> 15, s);
                pi = clamp17((br * wi + bi * wr + 16384) >>> 15, s);
            end
        endcase
        yar = ar + pr; yai = ai + pi; ybr = ar - pr; ybi = ai - pi;
        if (sc) begin
            yar = (yar + 1) >>> 1; yai = (yai + 1) >>> 1;
            ybr = (ybr + 1) >>> 1; ybi = (ybi + 1) >>> 1;
        end
        return mk(yar, yai, ybr, ybi, s, 1'b0);
    endfunction

    task automatic monitor();
        exp_t e;
        if (hold_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_ya_re", ya_re, h_ya_re);
            chk("hold_ya_im", ya_im, h_ya_im);
            chk("hold_yb_re", yb_re, h_yb_re);
            chk("hold_yb_im", yb_im, h_yb_im);
            chk("hold_sat", sat, h_sat);
            hold_v = 1'b0;
        end
        if (out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 0);
            hold_v = 1'b1;
            h_ya_re = ya_re; h_ya_im = ya_im; h_yb_re = yb_re; h_yb_im = yb_im; h_sat = sat;
        end
        if (out_ready) chk("in_ready", in_ready, 1);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", out_valid, 0);
            end else begin
                e = q.pop_front();
                chk("ya_re", ya_re, e.ya_re);
                chk("ya_im", ya_im, e.ya_im);
                chk("yb_re", yb_re, e.yb_re);
                chk("yb_im", yb_im, e.yb_im);
                chk("sat", sat, e.sat);
                if (e.lat) chk("latency", cyc - e.acc, 3);
                n_out++;
            end
        end
    endtask

    // One clock: check at negedge, then update out_ready just after posedge.
    task automatic tick();
        @(negedge clock);
        monitor();
        @(posedge clock);
        cyc++;
        #1;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
        #1;
    endtask

    task automatic send(input longint ar, input longint ai, input longint br, input longint bi,
                        input logic [1:0] m, input longint wr, input longint wi, input logic sc,
                        input exp_t e);
        xa_re = DATA_W'(ar); xa_im = DATA_W'(ai);
        xb_re = DATA_W'(br); xb_im = DATA_W'(bi);
        tw_mode = m; tw_re = TW_W'(wr); tw_im = TW_W'(wi); scale_en = sc;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                e.acc = cyc;
                q.push_back(e);
                tick();
                return;
            end
            tick();
        end
        chk("accept_timeout", in_ready, 1);
    endtask

    task automatic send_m(input longint ar, input longint ai, input longint br, input longint bi,
                          input logic [1:0] m, input longint wr, input longint wi, input logic sc);
        send(ar, ai, br, bi, m, wr, wi, sc, model(ar, ai, br, bi, m, wr, wi, sc));
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        xa_re = '0; xa_im = '0; xb_re = '0; xb_im = '0;
        tw_mode = '0; tw_re = '0; tw_im = '0; scale_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ya_re", ya_re, 0);
        chk("rst_yb_im", yb_im, 0);
        chk("rst_sat", sat, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;

        send(100, 50, 30, -20, 2'd0, 0, 0, 1'b0, mk(130, 30, 70, 70, 1'b0, 1'b1));
        drain();
        send(3, 0, 0, 0, 2'd0, 0, 0, 1'b1, mk(2, 0, 2, 0, 1'b0, 1'b1));
        drain();
        send(100, 50, 30, -20, 2'd1, 0, 0, 1'b0, mk(80, 20, 120, 80, 1'b0, 1'b1));
        drain();
        send(0, 0, 1000, 0, 2'd3, 23170, -23170, 1'b0, mk(707, -707, -707, 707, 1'b0, 1'b1));
        drain();
        send(0, 0, -32768, -32768, 2'd3, -32768, -32768, 1'b0, mk(0, 65535, 0, -65535, 1'b1, 1'b1));
        drain();

        // Back-to-back stream with a 5-cycle downstream stall after the third accept.
        n_out = 0;
        send_m(1234, -567, -20000, 15000, 2'd3, 30000, -12000, 1'b0);
        send_m(-32768, 32767, 32767, -32768, 2'd1, 5, 5, 1'b1);
        stall_left = 5;
        send_m(500, -500, -32768, 100, 2'd2, 77, -77, 1'b0);
        send_m(-100, 200, 32767, 32767, 2'd3, 32767, 32767, 1'b1);
        send_m(7, -7, -3, 3, 2'd0, 9, 9, 1'b1);
        send_m(0, 0, -32768, 0, 2'd3, -32768, 0, 1'b0);
        drain();
        chk("stream_count", n_out, 6);

        // Reset with three samples in flight.
        send_m(11, 12, 13, 14, 2'd0, 0, 0, 1'b0);
        send_m(21, 22, 23, 24, 2'd1, 0, 0, 1'b0);
        send_m(31, 32, 33, 34, 2'd2, 0, 0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_ya_re", ya_re, 0);
        chk("midrst_ya_im", ya_im, 0);
        chk("midrst_yb_re", yb_re, 0);
        chk("midrst_yb_im", yb_im, 0);
        chk("midrst_sat", sat, 0);
        chk("midrst_in_ready", in_ready, 1);
        q.delete();
        in_valid = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (8) tick();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        send(10, 20, 5, -7, 2'd2, 0, 0, 1'b0, mk(5, 27, 15, 13, 1'b0, 1'b1));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
